// File: rtl/sda_ctrl_if.sv
// SDA controller bus: mode requests from the slave FSM, tx data in, registered SDA and status out.
interface sda_ctrl_if;
  logic       scl_in;
  logic       tx_out;
  logic [1:0] sda_mode;
  logic       mode_load;
  logic       mode_force;
  logic       sda_out;
  logic [1:0] cur_mode;
  logic       busy;
  logic       applied;

  modport master (
    output scl_in, tx_out, sda_mode, mode_load, mode_force,
    input  sda_out, cur_mode, busy, applied
  );

  modport slave (
    input  scl_in, tx_out, sda_mode, mode_load, mode_force,
    output sda_out, cur_mode, busy, applied
  );
endinterface

// File: rtl/sda_ctrl.sv
// Registered SDA mode controller: queued mode requests take effect HOLD_CYCLES after an SCL fall,
// so SDA only moves while SCL is low.
module sda_ctrl #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [1:0]  RESET_MODE  = 2'b00
) (
  input  logic       clk,
  input  logic       n_rst,
  sda_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_FALL = 2'd1;
  localparam logic [1:0] S_HOLD      = 2'd2;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES);

  logic [1:0] state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [3:0] count_inc;
  logic [1:0] pend_q, pend_d;
  logic [1:0] cur_q, cur_d;
  logic       scl_prev_q;
  logic       sda_q, sda_d;
  logic       applied_q, applied_d;
  logic       fall;
  logic       hold_done;

  assign fall      = scl_prev_q & ~bus.scl_in;
  assign count_inc = count_q + 4'd1;

  // count_q holds cycles elapsed since the fall; the update edge is the one where it would reach
  // HOLD_LAST, so with HOLD_CYCLES==1 the apply happens straight out of WAIT_FALL.
  assign hold_done = ((state_q == S_HOLD) && (count_inc == HOLD_LAST)) ||
                     ((state_q == S_WAIT_FALL) && fall && (HOLD_LAST == 4'd1));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pend_d    = pend_q;
    cur_d     = cur_q;
    applied_d = 1'b0;
    if (bus.mode_force) begin
      cur_d     = bus.sda_mode;
      applied_d = 1'b1;
      state_d   = S_IDLE;
      count_d   = '0;
    end else begin
      if (bus.mode_load) pend_d = bus.sda_mode;
      if (hold_done) begin
        cur_d     = pend_q;
        applied_d = 1'b1;
        count_d   = '0;
        state_d   = bus.mode_load ? S_WAIT_FALL : S_IDLE;
      end else begin
        case (state_q)
          S_IDLE:      if (bus.mode_load) state_d = S_WAIT_FALL;
          S_WAIT_FALL: if (fall) begin
                         state_d = S_HOLD;
                         count_d = 4'd1;
                       end
          S_HOLD:      count_d = count_inc;
          default:     state_d = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    case (cur_q)
      2'b01:   sda_d = 1'b0;
      2'b11:   sda_d = bus.tx_out;
      default: sda_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      pend_q     <= '0;
      cur_q      <= RESET_MODE;
      scl_prev_q <= 1'b1;
      sda_q      <= 1'b1;
      applied_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      cur_q      <= cur_d;
      scl_prev_q <= bus.scl_in;
      sda_q      <= sda_d;
      applied_q  <= applied_d;
    end
  end

  assign bus.sda_out  = sda_q;
  assign bus.cur_mode = cur_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.applied  = applied_q;

endmodule

// File: tb/tb_sda_ctrl.sv
// Bench for sda_ctrl: three instances (HOLD_CYCLES 1, 2, 15) share stimulus and are checked
// against a cycle-arithmetic reference model.
module tb_sda_ctrl;

  localparam int HV [3] = '{1, 2, 15};

  logic       clk = 1'b0;
  logic       n_rst;
  logic       scl, tx, load, frc;
  logic [1:0] mode;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sda_ctrl_if if0 ();
  sda_ctrl_if if1 ();
  sda_ctrl_if if2 ();

  assign if0.scl_in = scl;  assign if0.tx_out = tx;  assign if0.sda_mode = mode;
  assign if0.mode_load = load;  assign if0.mode_force = frc;
  assign if1.scl_in = scl;  assign if1.tx_out = tx;  assign if1.sda_mode = mode;
  assign if1.mode_load = load;  assign if1.mode_force = frc;
  assign if2.scl_in = scl;  assign if2.tx_out = tx;  assign if2.sda_mode = mode;
  assign if2.mode_load = load;  assign if2.mode_force = frc;

  sda_ctrl #(.HOLD_CYCLES(1),  .RESET_MODE(2'b00)) u_h1  (.clk(clk), .n_rst(n_rst), .bus(if0));
  sda_ctrl #(.HOLD_CYCLES(2),  .RESET_MODE(2'b00)) u_h2  (.clk(clk), .n_rst(n_rst), .bus(if1));
  sda_ctrl #(.HOLD_CYCLES(15), .RESET_MODE(2'b00)) u_h15 (.clk(clk), .n_rst(n_rst), .bus(if2));

  logic       d_sda [3];
  logic [1:0] d_cur [3];
  logic       d_busy [3];
  logic       d_app [3];

  assign d_sda[0] = if0.sda_out;  assign d_cur[0] = if0.cur_mode;
  assign d_busy[0] = if0.busy;    assign d_app[0] = if0.applied;
  assign d_sda[1] = if1.sda_out;  assign d_cur[1] = if1.cur_mode;
  assign d_busy[1] = if1.busy;    assign d_app[1] = if1.applied;
  assign d_sda[2] = if2.sda_out;  assign d_cur[2] = if2.cur_mode;
  assign d_busy[2] = if2.busy;    assign d_app[2] = if2.applied;

  // Reference model: a pending request remembers the cycle number of its qualifying fall and
  // is applied once HOLD_CYCLES-1 further cycles have elapsed.
  int         cyc;
  logic       m_prev;
  bit         m_pend [3];
  bit         m_seen [3];
  int         m_F [3];
  logic [1:0] m_pmode [3];
  logic [1:0] m_cur [3];
  logic       m_sda [3];
  logic       m_app [3];

  task automatic model_reset();
    m_prev = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 0; m_seen[i] = 0; m_F[i] = 0;
      m_pmode[i] = 2'b00; m_cur[i] = 2'b00; m_sda[i] = 1'b1; m_app[i] = 1'b0;
    end
  endtask

  // Advance the model with the inputs present in this cycle, then let the DUT take the edge.
  task automatic step();
    logic fall;
    bit   due;
    fall   = m_prev & ~scl;
    m_prev = scl;
    for (int i = 0; i < 3; i++) begin
      m_sda[i] = (m_cur[i] == 2'b01) ? 1'b0 : (m_cur[i] == 2'b11) ? tx : 1'b1;
      m_app[i] = 1'b0;
      if (frc) begin
        m_cur[i] = mode; m_app[i] = 1'b1; m_pend[i] = 0; m_seen[i] = 0;
      end else begin
        due = 0;
        if (m_pend[i] && !m_seen[i] && fall) begin
          m_seen[i] = 1; m_F[i] = cyc;
        end
        if (m_pend[i] && m_seen[i] && (cyc - m_F[i] == HV[i] - 1)) due = 1;
        if (due) begin
          m_cur[i] = m_pmode[i]; m_app[i] = 1'b1; m_pend[i] = 0; m_seen[i] = 0;
        end
        if (load) begin
          m_pmode[i] = mode; m_pend[i] = 1;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({d_sda[i], d_cur[i], d_busy[i], d_app[i]} !== 5'b1_00_0_0) begin
        miscompares++;
        $display("FAIL reset_state[H=%0d] got sda/cur/busy/app=%b/%b/%b/%b expected 1/00/0/0",
                 HV[i], d_sda[i], d_cur[i], d_busy[i], d_app[i]);
      end
    end
    @(negedge clk);
    n_rst = 1'b1;
    frc = 1'b1; mode = 2'b01; step();
    frc = 1'b0; step();
    load = 1'b1; mode = 2'b10; step();
    load = 1'b0; scl = 1'b0; step();
    #1 n_rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({d_sda[i], d_cur[i], d_busy[i], d_app[i]} !== 5'b1_00_0_0) begin
        miscompares++;
        $display("FAIL async_reset[H=%0d] got sda/cur/busy/app=%b/%b/%b/%b expected 1/00/0/0",
                 HV[i], d_sda[i], d_cur[i], d_busy[i], d_app[i]);
      end
    end
    model_reset();
    @(negedge clk);
    scl = 1'b1; n_rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (d_cur[i] !== 2'b00 || d_app[i] !== 1'b0 || d_busy[i] !== 1'b0) begin
          miscompares++;
          $display("FAIL post_reset_quiet[H=%0d] got cur/app/busy=%b/%b/%b expected 00/0/0",
                   HV[i], d_cur[i], d_app[i], d_busy[i]);
        end
      end
    end
  endtask

  task automatic test_qualified();
    load = 1'b1; mode = 2'b01; step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (d_busy[i] !== 1'b1) begin
        miscompares++;
        $display("FAIL load_busy[H=%0d] got %b expected 1", HV[i], d_busy[i]);
      end
    end
    scl = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (d_app[i] !== (k == HV[i]) || d_cur[i] !== ((k >= HV[i]) ? 2'b01 : 2'b00) ||
            d_sda[i] !== ((k > HV[i]) ? 1'b0 : 1'b1)) begin
          miscompares++;
          $display("FAIL qualified_apply[H=%0d,F+%0d] got app/cur/sda=%b/%b/%b expected %b/%b/%b",
                   HV[i], k, d_app[i], d_cur[i], d_sda[i], (k == HV[i]),
                   (k >= HV[i]) ? 2'b01 : 2'b00, (k > HV[i]) ? 1'b0 : 1'b1);
        end
        if (k != HV[i]) begin
          vectors++;
          if (d_busy[i] !== (k < HV[i])) begin
            miscompares++;
            $display("FAIL qualified_busy[H=%0d,F+%0d] got %b expected %b",
                     HV[i], k, d_busy[i], (k < HV[i]));
          end
        end
      end
      if (k == 3) scl = 1'b1;
      if (k == 4) scl = 1'b0;
    end
    scl = 1'b1; step();
  endtask

  task automatic test_no_fall();
    load = 1'b1; mode = 2'b11; step();
    load = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tx = 1'($urandom);
      step();
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (d_busy[i] !== 1'b1 || d_cur[i] !== 2'b01) begin
          miscompares++;
          $display("FAIL no_fall_pending[H=%0d] got busy/cur=%b/%b expected 1/01",
                   HV[i], d_busy[i], d_cur[i]);
        end
      end
    end
    frc = 1'b1; mode = 2'b10; step();
    frc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({d_cur[i], d_app[i], d_busy[i], d_sda[i]} !== 5'b10_1_0_0) begin
        miscompares++;
        $display("FAIL force_t1[H=%0d] got cur/app/busy/sda=%b/%b/%b/%b expected 10/1/0/0",
                 HV[i], d_cur[i], d_app[i], d_busy[i], d_sda[i]);
      end
    end
    step();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (d_sda[i] !== 1'b1 || d_app[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL force_t2[H=%0d] got sda/app=%b/%b expected 1/0", HV[i], d_sda[i], d_app[i]);
      end
    end
  endtask

  task automatic test_overwrite();
    int pulses;
    frc = 1'b1; mode = 2'b00; step();
    frc = 1'b0;
    load = 1'b1; mode = 2'b01; step();
    load = 1'b0; scl = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (d_app[2] === 1'b1) pulses++;
      vectors++;
      if (d_app[2] !== (k == 15) || d_cur[2] !== ((k >= 15) ? 2'b10 : 2'b00)) begin
        miscompares++;
        $display("FAIL overwrite_hold[F+%0d] got app/cur=%b/%b expected %b/%b",
                 k, d_app[2], d_cur[2], (k == 15), (k >= 15) ? 2'b10 : 2'b00);
      end
      load = (k == 4);
      mode = 2'b10;
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL overwrite_pulses got %0d expected 1", pulses);
    end
    frc = 1'b1; mode = 2'b00; step();
    frc = 1'b0; scl = 1'b1; step();
  endtask

  task automatic test_load_on_apply();
    load = 1'b1; mode = 2'b01; step();
    load = 1'b0; scl = 1'b0; step();
    load = 1'b1; mode = 2'b10; step();
    load = 1'b0;
    vectors++;
    if (d_cur[1] !== 2'b01 || d_app[1] !== 1'b1 || d_busy[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL load_on_apply_edge got cur/app/busy=%b/%b/%b expected 01/1/1",
               d_cur[1], d_app[1], d_busy[1]);
    end
    step();
    vectors++;
    if (d_cur[1] !== 2'b01 || d_app[1] !== 1'b0 || d_busy[1] !== 1'b1 || d_sda[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL load_on_apply_hold got cur/app/busy/sda=%b/%b/%b/%b expected 01/0/1/0",
               d_cur[1], d_app[1], d_busy[1], d_sda[1]);
    end
    scl = 1'b1; step();
    scl = 1'b0; step();
    vectors++;
    if (d_cur[1] !== 2'b01) begin
      miscompares++;
      $display("FAIL load_on_apply_f1 got cur=%b expected 01", d_cur[1]);
    end
    step();
    vectors++;
    if (d_cur[1] !== 2'b10 || d_app[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL load_on_apply_second got cur/app=%b/%b expected 10/1", d_cur[1], d_app[1]);
    end
    scl = 1'b1; step();
  endtask

  task automatic test_transmit();
    logic txp;
    frc = 1'b1; mode = 2'b11; step();
    frc = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tx = 1'($urandom);
      txp = tx;
      step();
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (d_sda[i] !== txp) begin
          miscompares++;
          $display("FAIL transmit[H=%0d,%0d] got sda=%b expected %b", HV[i], k, d_sda[i], txp);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 2) == 0) scl = ~scl;
      load = ($urandom_range(0, 5) == 0);
      frc  = ($urandom_range(0, 39) == 0);
      mode = 2'($urandom);
      tx   = 1'($urandom);
      step();
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (d_sda[i] !== m_sda[i] || d_cur[i] !== m_cur[i] ||
            d_busy[i] !== m_pend[i] || d_app[i] !== m_app[i]) begin
          miscompares++;
          $display("FAIL random[H=%0d,%0d] got sda/cur/busy/app=%b/%b/%b/%b expected %b/%b/%b/%b",
                   HV[i], k, d_sda[i], d_cur[i], d_busy[i], d_app[i],
                   m_sda[i], m_cur[i], m_pend[i], m_app[i]);
        end
      end
    end
    load = 1'b0; frc = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; scl = 1'b1; tx = 1'b0; load = 1'b0; frc = 1'b0; mode = 2'b00;
    cyc = 0;
    model_reset();
    test_reset();
    test_qualified();
    test_no_fall();
    test_overwrite();
    test_load_on_apply();
    test_transmit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
